// File: rtl/dmem_param_if.sv
// Request/response bundle for dmem_param: one request channel, one response pulse.
// Latency: a response follows one cycle after an accepted request; no pipelining inside the bundle.
// Backpressure: req_ready gates requests; responses cannot be stalled.
interface dmem_param_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_param.sv
// Byte/half/word data memory that zero-fills itself after reset (DMEM_FAULT_EN adds misalign/range faults).
// Latency: response registered one cycle after accept; back-to-back accepts every cycle.
// Backpressure: req_ready low only while clearing; no response backpressure.
module dmem_param #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_param_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ptr;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic          fault;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_dat;

  assign accept = bus.req_valid & bus.req_ready;
  assign idx    = bus.req_addr[IW+1:2];
  assign lane   = bus.req_addr[1:0];

`ifdef DMEM_FAULT_EN
  logic misalign;
  logic out_of_range;
  // Half needs a[0]=0, word (and reserved size) needs a[1:0]=0.
  assign misalign     = ((bus.req_size == 2'b01) & lane[0]) | (bus.req_size[1] & (|lane));
  assign out_of_range = |(bus.req_addr >> (IW + 2));
  assign fault        = misalign | out_of_range;
`else
  // Upper address bits only wrap the address in this build.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr;
  assign fault       = 1'b0;
`endif

  // State register: reset always restarts the zero-fill.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Next state: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && ptr == IW'(DEPTH - 1)) state_nxt = RUN;
  end

  // Outputs of the FSM: accept requests only once the memory is clean.
  always_comb begin
    bus.req_ready = (state == RUN);
  end

  // Clear pointer walks every word exactly once per reset.
  always_ff @(posedge clk) begin
    if (!rst_n)              ptr <= '0;
    else if (state == CLEAR) ptr <= ptr + 1'b1;
  end

  // Lane enables and store data replicated onto every lane it may land in.
  always_comb begin
    be = 4'b1111;
    wd = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Memory array: zero-fill while clearing, masked stores while running.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (accept && bus.req_we && !fault) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
      end
    end
  end

  // Load path: pick the addressed lanes, right-align, then extend.
  always_comb begin
    rd_word  = mem[idx];
    rd_byte  = 8'(rd_word >> {lane, 3'b000});
    rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_dat = rd_word;
    case (bus.req_size)
      2'b00:   load_dat = bus.req_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      2'b01:   load_dat = bus.req_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default: ;
    endcase
  end

  // Response register: one-cycle pulse; stores and faulting loads return 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= accept;
      if (accept) bus.rsp_rdata <= (bus.req_we | fault) ? 32'h0 : load_dat;
    end
  end

`ifdef DMEM_FAULT_EN
  // Fault flag travels alongside the response pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) bus.rsp_err <= 1'b0;
    else        bus.rsp_err <= accept & fault;
  end
`else
  assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_param.sv
// Bench for dmem_param with DEPTH=8: directed literal cases plus randomized traffic.
// A byte-array model predicts ready/valid/rdata/err every cycle.
// Inputs change on negedge; outputs are compared on negedge.
module tb_dmem_param;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int NB    = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_param_if #(.AW(AW)) bus();

  dmem_param #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mmem [NB];
  int          clr_left = DEPTH;
  logic        exp_vld = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  bit          chk_on = 1'b0;

  task automatic model_access();
    int unsigned a;
    int          n;
    int          base;
    bit          flt;
    logic [31:0] v;
    a    = bus.req_addr;
    n    = (bus.req_size == 2'd0) ? 1 : (bus.req_size == 2'd1) ? 2 : 4;
    flt  = 1'b0;
`ifdef DMEM_FAULT_EN
    flt  = ((a % n) != 0) || (a >= NB);
`endif
    base = ((a % NB) / n) * n;
    exp_err = flt;
    if (bus.req_we) begin
      exp_rdata = 32'h0;
      if (!flt) for (int i = 0; i < n; i++) mmem[base + i] = bus.req_wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      if (!flt) begin
        for (int i = 0; i < n; i++) v = v | (32'(mmem[base + i]) << (8 * i));
        if (bus.req_signed && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
      end
      exp_rdata = v;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      clr_left  = DEPTH;
      exp_vld   = 1'b0;
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
    end else if (clr_left > 0) begin
      clr_left--;
      exp_vld = 1'b0;
      if (clr_left == 0) foreach (mmem[i]) mmem[i] = 8'h0;
    end else begin
      exp_vld = bus.req_valid;
      if (bus.req_valid) model_access();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", 32'(bus.req_ready), 32'(clr_left == 0));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_vld));
      if (exp_vld) begin
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_clear();
    int cnt = 0;
    while (!bus.req_ready && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("clear_cycles", cnt, DEPTH);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;

    // Reset state
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_err", 32'(bus.rsp_err), 32'h0);

    // Clear takes DEPTH cycles, then every word reads 0
    rst_n = 1'b1;
    count_clear();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0);
      chk("init_load", bus.rsp_rdata, 32'h0);
    end
    idle();

    // Lane-merged store and extended loads
    drive(1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678);
    drive(1'b1, 2'd0, 1'b0, 32'hA, 32'h000000AB);
    drive(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    chk("merge_word", bus.rsp_rdata, 32'h12AB5678);
    drive(1'b0, 2'd0, 1'b1, 32'hA, 32'h0);
    chk("byte_signed", bus.rsp_rdata, 32'hFFFFFFAB);
    drive(1'b0, 2'd0, 1'b0, 32'hA, 32'h0);
    chk("byte_unsigned", bus.rsp_rdata, 32'h000000AB);
    idle();

    // Store then load the same word on the very next cycle
    drive(1'b1, 2'd1, 1'b0, 32'h6, 32'h00008001);
    chk("b2b_valid0", 32'(bus.rsp_valid), 32'h1);
    drive(1'b0, 2'd1, 1'b1, 32'h6, 32'h0);
    chk("b2b_valid1", 32'(bus.rsp_valid), 32'h1);
    chk("b2b_half_signed", bus.rsp_rdata, 32'hFFFF8001);
    idle();
    chk("b2b_valid_end", 32'(bus.rsp_valid), 32'h0);

    // Reset while a load is in flight drops it and re-clears memory
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd2;
    bus.req_addr   = 32'h8;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_drop", 32'(bus.rsp_valid), 32'h0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    count_clear();
    drive(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    chk("after_reclear", bus.rsp_rdata, 32'h0);
    idle();

`ifdef DMEM_FAULT_EN
    drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h55AA55AA);
    drive(1'b1, 2'd2, 1'b0, 32'h2, 32'hDEADBEEF);
    chk("misalign_err", 32'(bus.rsp_err), 32'h1);
    drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk("misalign_nowrite", bus.rsp_rdata, 32'h55AA55AA);
    chk("aligned_err", 32'(bus.rsp_err), 32'h0);
    drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    chk("range_err", 32'(bus.rsp_err), 32'h1);
    chk("range_rdata", bus.rsp_rdata, 32'h0);
    idle();
`else
    drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    chk("wrap_store_err", 32'(bus.rsp_err), 32'h0);
    drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    chk("wrap_load", bus.rsp_rdata, 32'hCAFEF00D);
    chk("wrap_load_err", 32'(bus.rsp_err), 32'h0);
    idle();
`endif

    // Randomized traffic, with one reset pulse in the middle
    for (int it = 0; it < 800; it++) begin
      if (it == 400) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) begin
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, NB + 7)),
              32'($urandom));
      end else begin
        idle();
      end
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_param.md
DMEM_PARAM -- requirements
Module: dmem_param

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words; SHALL be a power of two and at least 4.
REQ-002 Parameter AW, default 32: byte-address width of req_addr.
REQ-003 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port req_valid, input, 1: request present.
REQ-006 Port req_ready, output, 1: block can accept a request.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_size, input, 2: 00 = byte, 01 = half, 10 = word; 11 is reserved and SHALL be treated as word.
REQ-009 Port req_signed, input, 1: sign-extend byte/half loads when 1; zero-extend when 0.
REQ-010 Port req_addr, input, AW: byte address.
REQ-011 Port req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port rsp_valid, output, 1: one-cycle pulse completing an accepted request.
REQ-013 Port rsp_rdata, output, 32: load result, right-aligned and extended; SHALL be 0 for stores.
REQ-014 Port rsp_err, output, 1: access fault; present only when DMEM_FAULT_EN is defined, otherwise driven 0.

Function
REQ-015 FSM states: CLEAR and RUN; reset SHALL enter CLEAR with the clear pointer at 0.
REQ-016 In CLEAR, each cycle SHALL write word[ptr] = 0 and increment ptr; after writing word DEPTH-1 the FSM SHALL move to RUN; duration SHALL be exactly DEPTH cycles.
REQ-017 req_ready SHALL be 0 in CLEAR and 1 in RUN; there is no response backpressure.
REQ-018 Accept = req_valid & req_ready; an accepted request SHALL produce rsp_valid exactly one cycle later; back-to-back accepts every cycle SHALL be supported.
REQ-019 Word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0]; upper address bits SHALL be ignored unless DMEM_FAULT_EN is defined.
REQ-020 Stores SHALL write only the addressed lanes: byte -> lane; half -> lanes {a1,0},{a1,1}; word -> all four. Other bytes SHALL be unchanged.
REQ-021 Loads SHALL read the word at the accept edge and register the selected lanes shifted to [7:0] or [15:0], then extend per req_signed.
REQ-022 A store followed by a load to the same word in the next cycle SHALL return the newly stored data.
REQ-023 Without DMEM_FAULT_EN, misaligned address bits SHALL be ignored: half uses a[1] only; word uses neither a[1] nor a[0].
REQ-024 rsp_valid SHALL never assert in CLEAR, nor in the cycle after reset is released.

Reset
REQ-025 While rst_n = 0 at a clock edge: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=CLEAR, ptr=0.
REQ-026 Reset asserted mid-CLEAR or mid-RUN SHALL restart the full clear; any request pending response SHALL be dropped without rsp_valid.

Configuration
REQ-027 Macro DMEM_FAULT_EN defined: rsp_err=1 with rsp_valid for a misaligned access (half with a[0]=1; word with a[1:0]!=0) or an out-of-range access (any req_addr bit above log2(DEPTH)+1 set); a faulting store SHALL NOT modify memory, and a faulting load SHALL return rsp_rdata=0.
REQ-028 Macro DMEM_FAULT_EN undefined: no fault logic; rsp_err SHALL be a constant 0; addresses SHALL wrap modulo DEPTH*4.

Verification (DEPTH=8)
REQ-029 Release rst_n -> req_ready=0 for exactly 8 cycles, then 1; a word load from 0x0,0x4,...,0x1C -> rsp_rdata=0 for each.
REQ-030 Word store 0x12345678 @0x8; byte store 0xAB @0xA; load word @0x8 -> 0x12AB5678; load byte signed @0xA -> 0xFFFFFFAB; load byte unsigned @0xA -> 0x000000AB.
REQ-031 Store half 0x8001 @0x6, then load half signed @0x6 on the next cycle -> 0xFFFF8001 with no idle cycle; rsp_valid high on 2 consecutive cycles.
REQ-032 Assert rst_n=0 for 1 cycle while a load is outstanding -> no rsp_valid; the 8-cycle clear restarts; previously written data reads as 0.
REQ-033 With DMEM_FAULT_EN defined: word store @0x2 -> rsp_err=1 and memory unchanged; load @0x20 -> rsp_err=1, rsp_rdata=0.
REQ-034 With DMEM_FAULT_EN undefined: word store 0xCAFEF00D @0x20, then load @0x0 -> 0xCAFEF00D and rsp_err=0.
